// File: rtl/apb_bridge_pkg.sv
// Shared types and address map for the AHB-to-APB bridge controller.
// The state encoding is 3 bits wide; the address map has three 64 MB slave windows.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
    localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
    localparam logic [31:0] MAP_TOP   = 32'h8C00_0000;
    localparam logic [2:0]  SEL_NONE  = 3'b000;

    function automatic logic [2:0] addr_to_sel(input logic [31:0] addr);
        logic [2:0] sel;
        sel = SEL_NONE;
        if (addr >= SLV0_BASE && addr < SLV1_BASE) begin
            sel = 3'b001;
        end else if (addr >= SLV1_BASE && addr < SLV2_BASE) begin
            sel = 3'b010;
        end else if (addr >= SLV2_BASE && addr < MAP_TOP) begin
            sel = 3'b100;
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_sel_decoder.sv
// Combinational address to one-hot APB slave select; zero latency.
// Addresses outside the map give an all-zero select.
module apb_sel_decoder
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NSEL   = 3
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NSEL-1:0]   sel_o
);

    assign sel_o = NSEL'(addr_to_sel(32'(addr_i)));

endmodule

// File: rtl/apb_bridge_controller.sv
// AHB-to-APB transfer sequencer: read SETUP one edge after valid, write SETUP two edges after.
// hreadyout stalls AHB during SETUP; optional macro APB_PREADY_EN stretches ACCESS on pready.
module apb_bridge_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwrite_reg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr_1,
    input  logic [ADDR_W-1:0] haddr_2,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hwdata_1,
`ifdef APB_PREADY_EN
    input  logic              pready,
`endif
    output logic              pwrite,
    output logic              penable,
    output logic [NSEL-1:0]   pselx,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout
);

    state_t            state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic              penable_q, penable_d;
    logic [NSEL-1:0]   pselx_q, pselx_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              hreadyout_q, hreadyout_d;

    logic [ADDR_W-1:0] dec_addr;
    logic [NSEL-1:0]   dec_sel;
    logic              in_access;
    logic              acc_done;

`ifdef APB_PREADY_EN
    localparam logic ACC_HREADY = 1'b0;
    assign acc_done = pready;
`else
    localparam logic ACC_HREADY = 1'b1;
    assign acc_done = 1'b1;
`endif

    assign in_access = (state_q == ST_RENABLE) || (state_q == ST_WENABLE) ||
                       (state_q == ST_WENABLEP);

    // A write SETUP takes the address from the stage matching how long the data lagged.
    always_comb begin
        dec_addr = haddr;
        if (state_q == ST_WWAIT) begin
            dec_addr = haddr_1;
        end else if (state_q == ST_WENABLEP && hwrite_reg) begin
            dec_addr = haddr_2;
        end
    end

    apb_sel_decoder #(
        .ADDR_W (ADDR_W),
        .NSEL   (NSEL)
    ) u_sel_decoder (
        .addr_i (dec_addr),
        .sel_o  (dec_sel)
    );

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        penable_d   = penable_q;
        pselx_d     = pselx_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;

        case (state_q)
            ST_IDLE:     if (valid) state_d = hwrite ? ST_WWAIT : ST_READ;
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_RENABLE,
            ST_WENABLE: begin
                if (acc_done) begin
                    if (valid) state_d = hwrite ? ST_WWAIT : ST_READ;
                    else       state_d = ST_IDLE;
                end
            end
            ST_WENABLEP: begin
                if (acc_done) begin
                    if (!hwrite_reg) state_d = ST_READ;
                    else             state_d = valid ? ST_WRITEP : ST_WRITE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase

        if (in_access && !acc_done) begin
            hreadyout_d = 1'b0;
        end else begin
            case (state_d)
                ST_IDLE, ST_WWAIT: begin
                    pselx_d     = '0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b1;
                end
                ST_READ: begin
                    paddr_d     = dec_addr;
                    pselx_d     = dec_sel;
                    pwrite_d    = 1'b0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end
                ST_WRITE, ST_WRITEP: begin
                    paddr_d     = dec_addr;
                    pwdata_d    = (state_q == ST_WENABLEP) ? hwdata_1 : hwdata;
                    pselx_d     = dec_sel;
                    pwrite_d    = 1'b1;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end
                default: begin
                    penable_d   = 1'b1;
                    hreadyout_d = ACC_HREADY;
                end
            endcase
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            pselx_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            penable_q   <= penable_d;
            pselx_q     <= pselx_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign pwrite    = pwrite_q;
    assign penable   = penable_q;
    assign pselx     = pselx_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_bridge_controller.sv
// Directed bench for apb_bridge_controller: cycle checks on SETUP/ACCESS phases plus a
// scoreboard of expected APB transfers popped on every completed ACCESS cycle.
module tb_apb_bridge_controller;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NSEL   = 3;
`ifdef APB_PREADY_EN
    localparam logic ACC_RDY = 1'b0;
`else
    localparam logic ACC_RDY = 1'b1;
`endif

    typedef struct packed {
        logic              wr;
        logic [NSEL-1:0]   sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } xfer_t;

    logic              hclk       = 1'b0;
    logic              hreset     = 1'b1;
    logic              valid      = 1'b0;
    logic              hwrite     = 1'b0;
    logic              hwrite_reg = 1'b0;
    logic [ADDR_W-1:0] haddr      = '0;
    logic [ADDR_W-1:0] haddr_1    = '0;
    logic [ADDR_W-1:0] haddr_2    = '0;
    logic [DATA_W-1:0] hwdata     = '0;
    logic [DATA_W-1:0] hwdata_1   = '0;
    logic              pready     = 1'b1;
    logic              pwrite, penable, hreadyout;
    logic [NSEL-1:0]   pselx;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;

    int    errors = 0;
    int    checks = 0;
    xfer_t exp_q[$];
    xfer_t got;
    xfer_t want;

    logic [ADDR_W-1:0] map_addr [5];
    logic [NSEL-1:0]   map_sel  [5];

    apb_bridge_controller #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NSEL   (NSEL)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .valid      (valid),
        .hwrite     (hwrite),
        .hwrite_reg (hwrite_reg),
        .haddr      (haddr),
        .haddr_1    (haddr_1),
        .haddr_2    (haddr_2),
        .hwdata     (hwdata),
        .hwdata_1   (hwdata_1),
`ifdef APB_PREADY_EN
        .pready     (pready),
`endif
        .pwrite     (pwrite),
        .penable    (penable),
        .pselx      (pselx),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .hreadyout  (hreadyout)
    );

    always #5 hclk = ~hclk;

    // AHB slave-interface pipeline stages feeding the controller
    always @(posedge hclk) begin
        haddr_1    <= haddr;
        haddr_2    <= haddr_1;
        hwdata_1   <= hwdata;
        hwrite_reg <= hwrite;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [NSEL-1:0] sel,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        xfer_t x;
        x.wr   = wr;
        x.sel  = sel;
        x.addr = addr;
        x.data = wr ? data : '0;
        exp_q.push_back(x);
    endtask

    // Every completed ACCESS cycle must match the oldest outstanding expectation
    always @(negedge hclk) begin
        if (!hreset && penable === 1'b1 && pready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed=APB access at %0h expected=none", paddr);
            end
            if (exp_q.size() != 0) begin
                want     = exp_q.pop_front();
                got.wr   = pwrite;
                got.sel  = pselx;
                got.addr = paddr;
                got.data = pwrite ? pwdata : '0;
                chk("sb_xfer", 72'(got), 72'(want));
            end
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk_setup(input string tag, input logic [NSEL-1:0] sel,
                             input logic [ADDR_W-1:0] addr, input logic wr,
                             input logic [DATA_W-1:0] data);
        chk({tag, ".setup.pselx"}, 72'(pselx), 72'(sel));
        chk({tag, ".setup.paddr"}, 72'(paddr), 72'(addr));
        chk({tag, ".setup.pwrite"}, 72'(pwrite), 72'(wr));
        chk({tag, ".setup.penable"}, 72'(penable), 72'(0));
        chk({tag, ".setup.hreadyout"}, 72'(hreadyout), 72'(0));
        if (wr) chk({tag, ".setup.pwdata"}, 72'(pwdata), 72'(data));
    endtask

    task automatic chk_access(input string tag, input logic [NSEL-1:0] sel);
        chk({tag, ".access.penable"}, 72'(penable), 72'(1));
        chk({tag, ".access.pselx"}, 72'(pselx), 72'(sel));
        chk({tag, ".access.hreadyout"}, 72'(hreadyout), 72'(ACC_RDY));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".idle.pselx"}, 72'(pselx), 72'(0));
        chk({tag, ".idle.penable"}, 72'(penable), 72'(0));
        chk({tag, ".idle.hreadyout"}, 72'(hreadyout), 72'(1));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pwrite"}, 72'(pwrite), 72'(0));
        chk({tag, ".penable"}, 72'(penable), 72'(0));
        chk({tag, ".pselx"}, 72'(pselx), 72'(0));
        chk({tag, ".paddr"}, 72'(paddr), 72'(0));
        chk({tag, ".pwdata"}, 72'(pwdata), 72'(0));
        chk({tag, ".hreadyout"}, 72'(hreadyout), 72'(1));
    endtask

    initial begin
        map_addr = '{32'h83FF_FFFC, 32'h8400_0000, 32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
        map_sel  = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};

        // reset state
        repeat (2) step();
        chk_reset("rst");
        hreset = 1'b0;
        step();
        chk_idle("idle0");

        // single read
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010;
        push(1'b0, 3'b001, 32'h8000_0010, '0);
        step();
        valid = 1'b0; haddr = '0;
        chk_setup("rd1", 3'b001, 32'h8000_0010, 1'b0, '0);
        step(); chk_access("rd1", 3'b001);
        step(); chk_idle("rd1");

        // single write, data one cycle behind the address
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0020;
        step();
        valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = 32'hDEAD_BEEF;
        chk("wr1.wwait.hreadyout", 72'(hreadyout), 72'(1));
        chk("wr1.wwait.pselx", 72'(pselx), 72'(0));
        push(1'b1, 3'b010, 32'h8400_0020, 32'hDEAD_BEEF);
        step();
        hwdata = '0;
        chk_setup("wr1", 3'b010, 32'h8400_0020, 1'b1, 32'hDEAD_BEEF);
        step(); chk_access("wr1", 3'b010);
        step(); chk_idle("wr1");

        // back-to-back writes: WWAIT -> WRITEP -> WENABLEP -> WRITE
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0000;
        step();
        haddr = 32'h8800_0004; hwdata = 32'h1111_0000;
        push(1'b1, 3'b100, 32'h8800_0000, 32'h1111_0000);
        step();
        chk_setup("bb.w0", 3'b100, 32'h8800_0000, 1'b1, 32'h1111_0000);
        valid = 1'b0; hwdata = 32'h2222_0004;
        push(1'b1, 3'b100, 32'h8800_0004, 32'h2222_0004);
        step();
        chk_access("bb.w0", 3'b100);
        step();
        chk_setup("bb.w1", 3'b100, 32'h8800_0004, 1'b1, 32'h2222_0004);
        hwrite = 1'b0; haddr = '0; hwdata = '0;
        step(); chk_access("bb.w1", 3'b100);
        step(); chk_idle("bb");

        // read followed directly by a write, no IDLE in between
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0000;
        push(1'b0, 3'b001, 32'h8000_0000, '0);
        step();
        chk_setup("rw.rd", 3'b001, 32'h8000_0000, 1'b0, '0);
        valid = 1'b0; hwrite = 1'b1; haddr = 32'h8400_0000;
        step();
        chk_access("rw.rd", 3'b001);
        valid = 1'b1;
        step();
        chk("rw.wwait.penable", 72'(penable), 72'(0));
        chk("rw.wwait.hreadyout", 72'(hreadyout), 72'(1));
        valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = 32'h1234_5678;
        push(1'b1, 3'b010, 32'h8400_0000, 32'h1234_5678);
        step();
        chk_setup("rw.wr", 3'b010, 32'h8400_0000, 1'b1, 32'h1234_5678);
        hwdata = '0;
        step(); chk_access("rw.wr", 3'b010);
        step(); chk_idle("rw");

        // decode boundaries, including unmapped addresses that still sequence
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; hwrite = 1'b0; haddr = map_addr[i];
            push(1'b0, map_sel[i], map_addr[i], '0);
            step();
            valid = 1'b0; haddr = '0;
            chk_setup($sformatf("map%0d", i), map_sel[i], map_addr[i], 1'b0, '0);
            step(); chk_access($sformatf("map%0d", i), map_sel[i]);
            step(); chk_idle($sformatf("map%0d", i));
        end

        // reset asserted in the middle of a write SETUP
        valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0010;
        step();
        valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = 32'hCAFE_F00D;
        step();
        chk("rstw.setup.pselx", 72'(pselx), 72'(3'b100));
        hreset = 1'b1;
        #1;
        chk_reset("rstw");
        exp_q.delete();
        step(); step();
        hreset = 1'b0; hwdata = '0;
        step();
        chk_idle("post_rst");

        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010;
        push(1'b0, 3'b001, 32'h8000_0010, '0);
        step();
        valid = 1'b0; haddr = '0;
        chk_setup("rd2", 3'b001, 32'h8000_0010, 1'b0, '0);
        step(); chk_access("rd2", 3'b001);
        step(); chk_idle("rd2");

`ifdef APB_PREADY_EN
        // ACCESS stretched by three cycles of pready low
        valid = 1'b1; hwrite = 1'b0; haddr = 32'h8400_0100;
        push(1'b0, 3'b010, 32'h8400_0100, '0);
        step();
        valid = 1'b0; haddr = '0; pready = 1'b0;
        chk_setup("prdy", 3'b010, 32'h8400_0100, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("prdy.wait.penable", 72'(penable), 72'(1));
            chk("prdy.wait.pselx", 72'(pselx), 72'(3'b010));
            chk("prdy.wait.paddr", 72'(paddr), 72'(32'h8400_0100));
            chk("prdy.wait.hreadyout", 72'(hreadyout), 72'(0));
        end
        pready = 1'b1;
        step();
        chk_idle("prdy");
`endif

        step();
        chk("sb_drained", 72'(exp_q.size()), 72'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_bridge_controller.md
Name: apb_bridge_controller

Overview:
- Sequences APB transfers for the AHB-to-APB bridge.
- Consumes the AHB slave-interface pipeline: valid, registered haddr/hwdata/hwrite stages.
- Drives APB SETUP/ACCESS phases: pselx, penable, pwrite, paddr, pwdata.
- Stalls the AHB master through hreadyout while an APB transfer is in flight.
- Sits between the AHB slave interface and the APB peripheral bus. One transfer at a time. Single-write pipelining is supported.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NSEL, 3, number of APB slave selects (one-hot).

Ports:
- hclk  in  1  bridge clock; all state on rising edge.
- hreset  in  1  reset, asynchronous, active-high.
- valid  in  1  qualified AHB transfer in address phase (in map, NONSEQ/SEQ, hreadyin).
- hwrite  in  1  current address-phase direction.
- hwrite_reg  in  1  hwrite delayed one cycle.
- haddr  in  ADDR_W  current AHB address.
- haddr_1  in  ADDR_W  haddr delayed 1 cycle.
- haddr_2  in  ADDR_W  haddr delayed 2 cycles.
- hwdata  in  DATA_W  current AHB write data.
- hwdata_1  in  DATA_W  hwdata delayed 1 cycle.
- pwrite  out  1  APB direction.
- penable  out  1  APB access phase.
- pselx  out  NSEL  one-hot APB select.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- hreadyout  out  1  high = bridge can accept or complete AHB transfer.

Behaviour:
- Reset: asynchronous on hreset=1. State=ST_IDLE. pwrite=0, penable=0, pselx=0, paddr=0, pwdata=0, hreadyout=1. Deassertion takes effect at the next hclk edge. Reset mid-transfer aborts with no APB completion.
- All outputs are registered. Each output is loaded on the edge that enters a state, from the present state and present inputs.
- Select decode of the driven address:
  - 0x8000_0000–0x83FF_FFFF → 3'b001
  - 0x8400_0000–0x87FF_FFFF → 3'b010
  - 0x8800_0000–0x8BFF_FFFF → 3'b100
  - else 3'b000
- Transitions:
  - IDLE: valid&hwrite→WWAIT; valid&!hwrite→READ; else IDLE.
  - WWAIT: valid→WRITEP; else→WRITE.
  - READ→RENABLE.
  - WRITE: valid→WENABLEP; else→WENABLE.
  - WRITEP→WENABLEP.
  - RENABLE, WENABLE: valid&!hwrite→READ; valid&hwrite→WWAIT; else→IDLE.
  - WENABLEP: !hwrite_reg→READ; hwrite_reg&valid→WRITEP; hwrite_reg&!valid→WRITE.
- Output loads on entry:
  - READ: paddr=haddr, pselx=dec(haddr), pwrite=0, penable=0, hreadyout=0.
  - WWAIT: pselx=0, penable=0, hreadyout=1.
  - WRITE/WRITEP from WWAIT: paddr=haddr_1, pwdata=hwdata, pselx=dec(haddr_1), pwrite=1, penable=0, hreadyout=0.
  - WRITE/WRITEP from WENABLEP: paddr=haddr_2, pwdata=hwdata_1, pselx=dec(haddr_2), pwrite=1, penable=0, hreadyout=0.
  - RENABLE/WENABLE/WENABLEP: penable=1; pselx/paddr/pwdata/pwrite held; hreadyout=1.
  - IDLE (from enable states): pselx=0, penable=0, hreadyout=1.
- Latency:
  - Read: valid sampled at edge N → SETUP at N+1 → ACCESS plus hreadyout=1 at N+2.
  - Write: SETUP at N+2, ACCESS at N+3.
- Invariants:
  - penable is never 1 unless pselx≠0 or the decode was 0.
  - penable is never 1 for two consecutive transfers without an intervening SETUP.
  - Unmapped address: pselx=0, FSM still sequences, no peripheral responds.
- Back-to-back read/write alternation must not insert IDLE.

Optional Feature:
- APB_PREADY_EN defined:
  - Adds input pready (1 bit).
  - In RENABLE/WENABLE/WENABLEP with pready=0: state and all APB outputs held, hreadyout=0.
  - Transition out only when pready=1.
- Not defined: no pready port; ACCESS is always one cycle.

Decomposition:
- Package apb_bridge_pkg:
  - state typedef (3-bit encoding, 8 states).
  - Address map constants: SLV0_BASE, SLV1_BASE, SLV2_BASE, MAP_TOP.
  - SEL_NONE.
  - Function addr_to_sel.
- Sub-module: apb_sel_decoder, combinational address→one-hot select. It is instantiated once, muxed on the address source. FSM and output registers stay in the top.

Test Plan:
- Single read, haddr=0x8000_0010, valid 1 cycle:
  - Edge+1: pselx=001, paddr=0x8000_0010, pwrite=0, hreadyout=0.
  - Edge+2: penable=1, hreadyout=1.
  - Edge+3: IDLE, pselx=0.
- Single write, haddr=0x8400_0020, hwdata=0xDEAD_BEEF next cycle:
  - WWAIT, then WRITE with paddr=0x8400_0020, pwdata=0xDEAD_BEEF, pselx=010, pwrite=1.
  - Then WENABLE with penable=1.
- Back-to-back writes 0x8800_0000 then 0x8800_0004, valid held:
  - Path WWAIT→WRITEP→WENABLEP→WRITE.
  - Second SETUP has paddr=0x8800_0004. hreadyout low during both SETUPs.
- Read 0x8000_0000 immediately followed by write 0x8400_0000:
  - RENABLE→WWAIT with no IDLE.
  - Both transfers appear on APB in order.
- Assert hreset during WRITE:
  - Outputs return to reset values immediately, before the next edge.
  - After release, FSM is in IDLE and the next read behaves as in the single-read scenario.
- With APB_PREADY_EN, pready=0 for 3 cycles in RENABLE:
  - penable/pselx/paddr stable and hreadyout=0 for 3 cycles.
  - Completion on the first pready=1 cycle.
